ccc_addr_assign: RTL and testbench
==================================

// Module: ccc_addr_assign
// PURPOSE
//  Target-side CCC decoder: consumes the byte stream from the target bus FSM and extracts the
//  address-assignment and reset CCCs (SETDASA, SETNEWDA, RSTDAA, RSTACT) for the main and virtual device.
//  Its outputs drive the CSR interface, which writes them into STBY_CR_DEVICE_ADDR / STBY_CR_VIRT_DEVICE_ADDR
//  and STBY_CR_CCC_CONFIG_RSTACT_PARAMS. It also generates the ACK/NACK decision for direct-CCC address headers.
// PARAMETERS
//  VirtEn     1      1: virtual-device address matching/assignment enabled; 0: virtual outputs tied 0
//  BcastAddr  7'h7E  I3C broadcast address
// PORTS
//  clk_i                       in   1  clock
//  rst_ni                      in   1  async active-low reset
//  bus_start_i                 in   1  pulse: START or Repeated START detected
//  bus_stop_i                  in   1  pulse: STOP detected
//  rx_byte_i                   in   8  received byte
//  rx_byte_valid_i             in   1  pulse: rx_byte_i valid
//  rx_is_addr_i                in   1  qualifies rx_byte_i as address header {addr[6:0],RnW}
//  static_addr_i/_valid_i      in   7/1 main static address + valid (from CSR)
//  dyn_addr_i/_valid_i         in   7/1 main dynamic address + valid (from CSR)
//  virt_static_addr_i/_valid_i in   7/1 virtual static address + valid
//  virt_dyn_addr_i/_valid_i    in   7/1 virtual dynamic address + valid
//  ack_valid_o                 out  1  pulse: ACK decision for last address header
//  ack_o                       out  1  1=ACK, 0=NACK (meaningful while ack_valid_o)
//  set_dasa_o                  out  7  assigned dynamic address (SETDASA) / 0 for RSTDAA
//  set_dasa_valid_o            out  1  pulse: commit SETDASA
//  set_dasa_virtual_device_o   out  1  qualifies set_dasa_valid_o / rstdaa_o as virtual device
//  rstdaa_o                    out  1  pulse: reset dynamic address
//  newda_o                     out  7  new dynamic address (SETNEWDA)
//  set_newda_o                 out  1  pulse: commit SETNEWDA
//  set_newda_virtual_device_o  out  1  qualifies set_newda_o as virtual device
//  rst_action_o                out  8  last accepted RSTACT defining byte
//  rst_action_valid_o          out  1  level: rst_action_o valid
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE. All outputs registered; pulses are exactly 1 cycle.
//  Codes: RSTDAA 8'h06 (bcast), RSTACT 8'h2A (bcast) / 8'h9A (direct), SETDASA 8'h87, SETNEWDA 8'h88.
//  FSM states: IDLE, BC_HDR, CCC_CODE, BC_DEF, DIR_DEF, DIR_SR, DIR_ADDR, DIR_DATA, RSTDAA_V, SKIP.
//  - IDLE: bus_start_i -> BC_HDR.
//  - BC_HDR: address byte == {BcastAddr,0} -> CCC_CODE; any other address -> SKIP.
//  - CCC_CODE: latch code.
//    06 -> SKIP and arm RSTDAA; 2A -> BC_DEF; 9A -> DIR_DEF; 87/88 -> DIR_SR; others -> SKIP.
//  - BC_DEF: data byte latched to rst_action_o, rst_action_valid_o=1 (held until next accepted RSTACT or reset).
//  - DIR_DEF: defining byte held pending -> DIR_SR.
//  - DIR_SR: bus_start_i -> DIR_ADDR.
//  - DIR_ADDR: address byte {BcastAddr,0} -> CCC_CODE (new CCC).
//    Otherwise match, with ack_valid_o pulse next cycle:
//      SETDASA:  static match, dyn not valid.
//      SETNEWDA: dyn match, dyn valid.
//      RSTACT:   dyn match, any RnW.
//    Main checked before virtual. On match: ack_o=1, remember main/virt, -> DIR_DATA. No match: ack_o=0, -> DIR_SR.
//  - DIR_DATA (SETDASA/SETNEWDA): data byte with bit0==0 and addr[7:1] not in {7'h00,BcastAddr} commits:
//    set_dasa_valid_o/set_newda_o pulse, address on set_dasa_o/newda_o, virtual flag set per match.
//    Invalid byte: no commit. Either way -> DIR_SR.
//    RSTACT match: commit pending defining byte as in BC_DEF on the cycle after ack; -> DIR_SR.
//  - SKIP: ignore bytes until bus_stop_i.
//  STOP in any state -> IDLE. If RSTDAA armed, STOP -> RSTDAA_V:
//    rstdaa_o=1, virtual=0 for 1 cycle, then (VirtEn) rstdaa_o=1, virtual=1 for 1 cycle; then IDLE.
//    bus_start_i during RSTDAA_V is latched and taken after the sequence.
//  Precedence: rx_byte_valid_i and bus_stop_i in same cycle -> byte processed first, then STOP.
//  bus_start_i in any state except IDLE/DIR_SR/RSTDAA_V -> BC_HDR (Sr aborts; pending commits dropped).
//  Byte with rx_is_addr_i mismatching the expected kind -> SKIP.
//  VirtEn=0: virtual matches never hit; virtual qualifiers constant 0.
//  Reset mid-operation: pending/pulsed outputs cleared immediately (async); rst_action_valid_o cleared.
// TESTING
//  S,{7E,0},87,Sr,{static 0x30,0},data 0x52,P (dyn invalid) -> ack_o=1, set_dasa_valid_o pulse, set_dasa_o=0x29, virt=0.
//  S,{7E,0},88,Sr,{virt dyn 0x11,0},0x44,P -> set_newda_o pulse, newda_o=0x22, set_newda_virtual_device_o=1.
//  S,{7E,0},06,P (VirtEn=1) -> rstdaa_o high 2 consecutive cycles; virtual=0 then 1; no pulse before STOP.
//  S,{7E,0},2A,0x01,P -> rst_action_o=0x01, rst_action_valid_o=1 held after P.
//  S,{7E,0},9A,0x02,Sr,{0x55,0} (no match) -> ack_o=0 and rst_action_valid_o stays 0.
//  S,{7E,0},87,Sr,{static,0},data 0xFD (bit0=1) -> ACK but no commit.
//  S,{7E,0},87,Sr,{static,0}, then rst_ni low -> all outputs 0; next frame decodes normally.

Source files
------------

// File: rtl/ccc_addr_assign_if.sv
// Byte stream from the target bus FSM, CSR address inputs and decoded CCC commit outputs.
// Single-cycle strobes; no backpressure: the decoder always accepts a presented byte.
interface ccc_addr_assign_if;
  logic       bus_start_i;
  logic       bus_stop_i;
  logic [7:0] rx_byte_i;
  logic       rx_byte_valid_i;
  logic       rx_is_addr_i;
  logic [6:0] static_addr_i;
  logic       static_addr_valid_i;
  logic [6:0] dyn_addr_i;
  logic       dyn_addr_valid_i;
  logic [6:0] virt_static_addr_i;
  logic       virt_static_addr_valid_i;
  logic [6:0] virt_dyn_addr_i;
  logic       virt_dyn_addr_valid_i;
  logic       ack_valid_o;
  logic       ack_o;
  logic [6:0] set_dasa_o;
  logic       set_dasa_valid_o;
  logic       set_dasa_virtual_device_o;
  logic       rstdaa_o;
  logic [6:0] newda_o;
  logic       set_newda_o;
  logic       set_newda_virtual_device_o;
  logic [7:0] rst_action_o;
  logic       rst_action_valid_o;

  modport slave (
    input  bus_start_i, bus_stop_i, rx_byte_i, rx_byte_valid_i, rx_is_addr_i,
    input  static_addr_i, static_addr_valid_i, dyn_addr_i, dyn_addr_valid_i,
    input  virt_static_addr_i, virt_static_addr_valid_i, virt_dyn_addr_i, virt_dyn_addr_valid_i,
    output ack_valid_o, ack_o, set_dasa_o, set_dasa_valid_o, set_dasa_virtual_device_o,
    output rstdaa_o, newda_o, set_newda_o, set_newda_virtual_device_o,
    output rst_action_o, rst_action_valid_o
  );

  modport master (
    output bus_start_i, bus_stop_i, rx_byte_i, rx_byte_valid_i, rx_is_addr_i,
    output static_addr_i, static_addr_valid_i, dyn_addr_i, dyn_addr_valid_i,
    output virt_static_addr_i, virt_static_addr_valid_i, virt_dyn_addr_i, virt_dyn_addr_valid_i,
    input  ack_valid_o, ack_o, set_dasa_o, set_dasa_valid_o, set_dasa_virtual_device_o,
    input  rstdaa_o, newda_o, set_newda_o, set_newda_virtual_device_o,
    input  rst_action_o, rst_action_valid_o
  );
endinterface

// File: rtl/ccc_addr_assign.sv
// Target-side decoder for SETDASA/SETNEWDA/RSTDAA/RSTACT; all outputs registered, 1 cycle after the byte.
// No backpressure: every presented byte is consumed in the cycle it is valid.
module ccc_addr_assign #(
  parameter bit         VirtEn    = 1'b1,
  parameter logic [6:0] BcastAddr = 7'h7E
) (
  input logic clk_i,
  input logic rst_ni,
  ccc_addr_assign_if.slave bus
);

  localparam logic [7:0] CccRstdaa    = 8'h06;
  localparam logic [7:0] CccRstactBc  = 8'h2A;
  localparam logic [7:0] CccRstactDir = 8'h9A;
  localparam logic [7:0] CccSetdasa   = 8'h87;
  localparam logic [7:0] CccSetnewda  = 8'h88;

  typedef enum logic [3:0] {
    ST_IDLE, ST_BC_HDR, ST_CCC_CODE, ST_BC_DEF, ST_DIR_DEF,
    ST_DIR_SR, ST_DIR_ADDR, ST_DIR_DATA, ST_RSTDAA_V, ST_SKIP
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] code_q, code_d;
  logic [7:0] def_q, def_d;
  logic       virt_q, virt_d;
  logic       arm_q, arm_d;
  logic       ack_vld_q, ack_vld_d, ack_q, ack_d;
  logic [6:0] dasa_q, dasa_d;
  logic       dasa_vld_q, dasa_vld_d, dasa_virt_q, dasa_virt_d;
  logic       rstdaa_q, rstdaa_d;
  logic [6:0] newda_q, newda_d;
  logic       newda_vld_q, newda_vld_d, newda_virt_q, newda_virt_d;
  logic [7:0] ra_q, ra_d;
  logic       ra_vld_q, ra_vld_d;

  logic [6:0] rx_addr;
  logic       rx_rnw, bcast_hdr, data_ok, main_hit, virt_hit;

  assign rx_addr   = bus.rx_byte_i[7:1];
  assign rx_rnw    = bus.rx_byte_i[0];
  assign bcast_hdr = bus.rx_is_addr_i && (bus.rx_byte_i == {BcastAddr, 1'b0});
  assign data_ok   = !rx_rnw && (rx_addr != 7'h00) && (rx_addr != BcastAddr);

  // Address match rules depend on which direct CCC is in flight.
  always_comb begin
    main_hit = 1'b0;
    virt_hit = 1'b0;
    case (code_q)
      CccSetdasa: begin
        main_hit = !rx_rnw && bus.static_addr_valid_i && (rx_addr == bus.static_addr_i)
                   && !bus.dyn_addr_valid_i;
        virt_hit = !rx_rnw && bus.virt_static_addr_valid_i && (rx_addr == bus.virt_static_addr_i)
                   && !bus.virt_dyn_addr_valid_i;
      end
      CccSetnewda: begin
        main_hit = !rx_rnw && bus.dyn_addr_valid_i && (rx_addr == bus.dyn_addr_i);
        virt_hit = !rx_rnw && bus.virt_dyn_addr_valid_i && (rx_addr == bus.virt_dyn_addr_i);
      end
      CccRstactDir: begin
        main_hit = bus.dyn_addr_valid_i && (rx_addr == bus.dyn_addr_i);
        virt_hit = bus.virt_dyn_addr_valid_i && (rx_addr == bus.virt_dyn_addr_i);
      end
      default: ;
    endcase
    virt_hit = virt_hit && VirtEn;
  end

  always_comb begin
    state_d      = state_q;
    code_d       = code_q;
    def_d        = def_q;
    virt_d       = virt_q;
    arm_d        = arm_q;
    ack_vld_d    = 1'b0;
    ack_d        = 1'b0;
    dasa_d       = dasa_q;
    dasa_vld_d   = 1'b0;
    dasa_virt_d  = 1'b0;
    rstdaa_d     = 1'b0;
    newda_d      = newda_q;
    newda_vld_d  = 1'b0;
    newda_virt_d = 1'b0;
    ra_d         = ra_q;
    ra_vld_d     = ra_vld_q;
    if (state_q == ST_RSTDAA_V) begin
      // Second half of RSTDAA (virtual device); a START seen here is honoured afterwards.
      rstdaa_d    = 1'b1;
      dasa_virt_d = 1'b1;
      dasa_d      = 7'h00;
      state_d     = bus.bus_start_i ? ST_BC_HDR : ST_IDLE;
    end else begin
      if (bus.bus_start_i) begin
        case (state_q)
          ST_IDLE:   state_d = ST_BC_HDR;
          ST_DIR_SR: state_d = ST_DIR_ADDR;
          default: begin
            state_d = ST_BC_HDR;
            arm_d   = 1'b0;
          end
        endcase
      end else begin
        case (state_q)
          ST_BC_HDR:
            if (bus.rx_byte_valid_i) state_d = bcast_hdr ? ST_CCC_CODE : ST_SKIP;
          ST_CCC_CODE:
            if (bus.rx_byte_valid_i) begin
              state_d = ST_SKIP;
              if (!bus.rx_is_addr_i) begin
                code_d = bus.rx_byte_i;
                case (bus.rx_byte_i)
                  CccRstdaa:               arm_d   = 1'b1;
                  CccRstactBc:             state_d = ST_BC_DEF;
                  CccRstactDir:            state_d = ST_DIR_DEF;
                  CccSetdasa, CccSetnewda: state_d = ST_DIR_SR;
                  default: ;
                endcase
              end
            end
          ST_BC_DEF:
            if (bus.rx_byte_valid_i) begin
              state_d = ST_SKIP;
              if (!bus.rx_is_addr_i) begin
                ra_d     = bus.rx_byte_i;
                ra_vld_d = 1'b1;
              end
            end
          ST_DIR_DEF:
            if (bus.rx_byte_valid_i) begin
              state_d = bus.rx_is_addr_i ? ST_SKIP : ST_DIR_SR;
              def_d   = bus.rx_byte_i;
            end
          ST_DIR_ADDR:
            if (bus.rx_byte_valid_i) begin
              if (!bus.rx_is_addr_i) begin
                state_d = ST_SKIP;
              end else if (bcast_hdr) begin
                state_d = ST_CCC_CODE;
              end else begin
                ack_vld_d = 1'b1;
                ack_d     = main_hit || virt_hit;
                virt_d    = !main_hit;
                state_d   = (main_hit || virt_hit) ? ST_DIR_DATA : ST_DIR_SR;
              end
            end
          ST_DIR_DATA:
            // Direct RSTACT needs no data byte: commit on the cycle the ACK is seen.
            if (code_q == CccRstactDir) begin
              ra_d     = def_q;
              ra_vld_d = 1'b1;
              state_d  = ST_DIR_SR;
            end else if (bus.rx_byte_valid_i) begin
              state_d = ST_DIR_SR;
              if (bus.rx_is_addr_i) begin
                state_d = ST_SKIP;
              end else if (data_ok && code_q == CccSetdasa) begin
                dasa_d      = rx_addr;
                dasa_vld_d  = 1'b1;
                dasa_virt_d = virt_q;
              end else if (data_ok) begin
                newda_d      = rx_addr;
                newda_vld_d  = 1'b1;
                newda_virt_d = virt_q;
              end
            end
          default: ;
        endcase
      end
      if (bus.bus_stop_i) begin
        state_d = ST_IDLE;
        if (arm_d) begin
          rstdaa_d = 1'b1;
          dasa_d   = 7'h00;
          arm_d    = 1'b0;
          state_d  = VirtEn ? ST_RSTDAA_V : ST_IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      code_q       <= 8'h00;
      def_q        <= 8'h00;
      virt_q       <= 1'b0;
      arm_q        <= 1'b0;
      ack_vld_q    <= 1'b0;
      ack_q        <= 1'b0;
      dasa_q       <= 7'h00;
      dasa_vld_q   <= 1'b0;
      dasa_virt_q  <= 1'b0;
      rstdaa_q     <= 1'b0;
      newda_q      <= 7'h00;
      newda_vld_q  <= 1'b0;
      newda_virt_q <= 1'b0;
      ra_q         <= 8'h00;
      ra_vld_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      code_q       <= code_d;
      def_q        <= def_d;
      virt_q       <= virt_d;
      arm_q        <= arm_d;
      ack_vld_q    <= ack_vld_d;
      ack_q        <= ack_d;
      dasa_q       <= dasa_d;
      dasa_vld_q   <= dasa_vld_d;
      dasa_virt_q  <= dasa_virt_d;
      rstdaa_q     <= rstdaa_d;
      newda_q      <= newda_d;
      newda_vld_q  <= newda_vld_d;
      newda_virt_q <= newda_virt_d;
      ra_q         <= ra_d;
      ra_vld_q     <= ra_vld_d;
    end
  end

  assign bus.ack_valid_o                = ack_vld_q;
  assign bus.ack_o                      = ack_q;
  assign bus.set_dasa_o                 = dasa_q;
  assign bus.set_dasa_valid_o           = dasa_vld_q;
  assign bus.set_dasa_virtual_device_o  = dasa_virt_q && VirtEn;
  assign bus.rstdaa_o                   = rstdaa_q;
  assign bus.newda_o                    = newda_q;
  assign bus.set_newda_o                = newda_vld_q;
  assign bus.set_newda_virtual_device_o = newda_virt_q && VirtEn;
  assign bus.rst_action_o               = ra_q;
  assign bus.rst_action_valid_o         = ra_vld_q;

endmodule

// File: tb/tb_ccc_addr_assign.sv
// Randomized frames against a rule-level model; expected output events queued, monitor pops and compares.
module tb_ccc_addr_assign;
  localparam logic [2:0] EV_ACK = 3'd1, EV_DASA = 3'd2, EV_NEWDA = 3'd3, EV_RSTDAA = 3'd4, EV_RA = 3'd5;
  localparam logic [7:0] BC_W = {7'h7E, 1'b0};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [11:0] sb[$];

  // Model view of CSR addresses and of the sticky RSTACT register.
  logic [6:0] m_sa, m_da, m_vsa, m_vda;
  bit         m_sv, m_dv, m_vsv, m_vdv;
  logic [7:0] m_ra = 8'h00;
  bit         m_rav = 1'b0;
  logic [7:0] ra_prev = 8'h00;
  logic       rav_prev = 1'b0;

  always #5 clk = ~clk;

  ccc_addr_assign_if bus ();

  ccc_addr_assign #(.VirtEn(1'b1), .BcastAddr(7'h7E)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  function automatic bit hit(input logic [7:0] code, input logic [6:0] a, input bit rnw,
                             input logic [6:0] sa, input bit sv, input logic [6:0] da, input bit dv);
    case (code)
      8'h87:   return !rnw && sv && a == sa && !dv;
      8'h88:   return !rnw && dv && a == da;
      8'h9A:   return dv && a == da;
      default: return 1'b0;
    endcase
  endfunction

  task automatic push(input logic [2:0] k, input logic [7:0] v, input bit vr);
    sb.push_back({k, v, vr});
  endtask

  task automatic push_ra(input logic [7:0] v);
    if (!m_rav || m_ra != v) push(EV_RA, v, 1'b0);
    m_rav = 1'b1;
    m_ra  = v;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic got(input string nm, input logic [11:0] act);
    logic [11:0] exp;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL %s unexpected event: got %h, none required", nm, act);
    end else begin
      exp = sb.pop_front();
      if (act !== exp) begin
        n_bad++;
        $display("FAIL %s: got %h, required %h", nm, act, exp);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.ack_valid_o)  got("ack", {EV_ACK, 7'b0, bus.ack_o, 1'b0});
      if (bus.set_dasa_valid_o)
        got("setdasa", {EV_DASA, 1'b0, bus.set_dasa_o, bus.set_dasa_virtual_device_o});
      if (bus.set_newda_o)
        got("setnewda", {EV_NEWDA, 1'b0, bus.newda_o, bus.set_newda_virtual_device_o});
      if (bus.rstdaa_o)
        got("rstdaa", {EV_RSTDAA, 1'b0, bus.set_dasa_o, bus.set_dasa_virtual_device_o});
      if (bus.rst_action_valid_o && (!rav_prev || bus.rst_action_o != ra_prev))
        got("rstact", {EV_RA, bus.rst_action_o, 1'b0});
    end
    ra_prev  <= bus.rst_action_o;
    rav_prev <= bus.rst_action_valid_o;
  end

  function automatic logic [29:0] all_outs();
    return {bus.ack_valid_o, bus.ack_o, bus.set_dasa_o, bus.set_dasa_valid_o,
            bus.set_dasa_virtual_device_o, bus.rstdaa_o, bus.newda_o, bus.set_newda_o,
            bus.set_newda_virtual_device_o, bus.rst_action_o, bus.rst_action_valid_o};
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drv_start();
    bus.bus_start_i = 1'b1; cyc(1); bus.bus_start_i = 1'b0; cyc(2);
  endtask

  task automatic drv_byte(input logic [7:0] b, input logic a);
    bus.rx_byte_i = b; bus.rx_is_addr_i = a; bus.rx_byte_valid_i = 1'b1;
    cyc(1);
    bus.rx_byte_valid_i = 1'b0; bus.rx_is_addr_i = 1'b0;
    cyc(2);
  endtask

  task automatic drv_stop();
    bus.bus_stop_i = 1'b1; cyc(1); bus.bus_stop_i = 1'b0; cyc(4);
  endtask

  task automatic set_csr(input logic [6:0] sa, input bit sv, input logic [6:0] da, input bit dv,
                         input logic [6:0] vsa, input bit vsv, input logic [6:0] vda, input bit vdv);
    m_sa = sa; m_sv = sv; m_da = da; m_dv = dv; m_vsa = vsa; m_vsv = vsv; m_vda = vda; m_vdv = vdv;
    bus.static_addr_i = sa;       bus.static_addr_valid_i = sv;
    bus.dyn_addr_i = da;          bus.dyn_addr_valid_i = dv;
    bus.virt_static_addr_i = vsa; bus.virt_static_addr_valid_i = vsv;
    bus.virt_dyn_addr_i = vda;    bus.virt_dyn_addr_valid_i = vdv;
  endtask

  // Direct CCC frame; abort=1 replaces the data byte with a Repeated START.
  task automatic f_direct(input logic [7:0] code, input logic [7:0] def, input logic [6:0] tgt,
                          input bit rnw, input logic [7:0] data, input bit abort, input bit stop);
    bit mh, vh;
    mh = hit(code, tgt, rnw, m_sa, m_sv, m_da, m_dv);
    vh = hit(code, tgt, rnw, m_vsa, m_vsv, m_vda, m_vdv);
    drv_start();
    drv_byte(BC_W, 1'b1);
    drv_byte(code, 1'b0);
    if (code == 8'h9A) drv_byte(def, 1'b0);
    drv_start();
    push(EV_ACK, {7'b0, mh | vh}, 1'b0);
    if ((mh | vh) && code == 8'h9A) push_ra(def);
    drv_byte({tgt, rnw}, 1'b1);
    if ((mh | vh) && code != 8'h9A) begin
      if (abort) begin
        drv_start();
      end else begin
        if (!data[0] && data[7:1] != 7'h00 && data[7:1] != 7'h7E)
          push(code == 8'h87 ? EV_DASA : EV_NEWDA, {1'b0, data[7:1]}, !mh);
        drv_byte(data, 1'b0);
      end
    end
    if (stop) drv_stop();
  endtask

  task automatic f_rstdaa();
    drv_start(); drv_byte(BC_W, 1'b1); drv_byte(8'h06, 1'b0);
    push(EV_RSTDAA, 8'h00, 1'b0);
    push(EV_RSTDAA, 8'h00, 1'b1);
    drv_stop();
  endtask

  task automatic f_bc_rstact(input logic [7:0] v);
    drv_start(); drv_byte(BC_W, 1'b1); drv_byte(8'h2A, 1'b0);
    push_ra(v);
    drv_byte(v, 1'b0);
    drv_stop();
  endtask

  task automatic f_ignored(input bit bcast, input logic [7:0] b0, input logic [7:0] b1);
    drv_start();
    drv_byte(bcast ? BC_W : b0, 1'b1);
    drv_byte(b0, 1'b0);
    drv_byte(b1, 1'b0);
    drv_stop();
  endtask

  function automatic logic [6:0] raddr();
    return 7'($urandom_range(8, 'h77));
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1);
  end

  initial begin
    logic [7:0] codes[3];
    logic [6:0] tgt;
    logic [7:0] data, code;
    codes[0] = 8'h87; codes[1] = 8'h88; codes[2] = 8'h9A;
    bus.bus_start_i = 1'b0; bus.bus_stop_i = 1'b0; bus.rx_byte_i = 8'h00;
    bus.rx_byte_valid_i = 1'b0; bus.rx_is_addr_i = 1'b0;
    set_csr(7'h30, 1'b1, 7'h00, 1'b0, 7'h00, 1'b0, 7'h00, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 32'(all_outs()), 32'h0);
    rst_n = 1'b1;
    cyc(2);

    f_direct(8'h87, 8'h00, 7'h30, 1'b0, 8'h52, 1'b0, 1'b1);
    check("setdasa_value", 32'(bus.set_dasa_o), 32'h29);
    set_csr(7'h30, 1'b1, 7'h20, 1'b1, 7'h00, 1'b0, 7'h11, 1'b1);
    f_direct(8'h88, 8'h00, 7'h11, 1'b0, 8'h44, 1'b0, 1'b1);
    check("newda_value", 32'(bus.newda_o), 32'h22);
    f_rstdaa();
    f_direct(8'h9A, 8'h02, 7'h55, 1'b0, 8'h00, 1'b0, 1'b1);
    check("rstact_nomatch_valid", 32'(bus.rst_action_valid_o), 32'h0);
    f_bc_rstact(8'h01);
    check("rstact_bc_held", 32'({bus.rst_action_valid_o, bus.rst_action_o}), 32'h101);
    set_csr(7'h30, 1'b1, 7'h00, 1'b0, 7'h00, 1'b0, 7'h00, 1'b0);
    f_direct(8'h87, 8'h00, 7'h30, 1'b0, 8'hFD, 1'b0, 1'b1);

    f_direct(8'h87, 8'h00, 7'h30, 1'b0, 8'h00, 1'b1, 1'b0);
    cyc(2);
    rst_n = 1'b0;
    #2;
    check("midframe_reset_outputs", 32'(all_outs()), 32'h0);
    check("midframe_reset_queue", 32'(sb.size()), 32'h0);
    m_rav = 1'b0; m_ra = 8'h00;
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
    f_direct(8'h87, 8'h00, 7'h30, 1'b0, 8'h52, 1'b0, 1'b1);
    check("post_reset_setdasa", 32'(bus.set_dasa_o), 32'h29);

    for (int i = 0; i < 300; i++) begin
      set_csr(raddr(), ($urandom % 4) != 0, raddr(), $urandom % 2,
              raddr(), ($urandom % 4) != 0, raddr(), $urandom % 2);
      case ($urandom % 5)
        0: tgt = m_sa;
        1: tgt = m_da;
        2: tgt = m_vsa;
        3: tgt = m_vda;
        default: tgt = raddr();
      endcase
      data = ($urandom % 10 < 7) ? {raddr(), 1'b0} : 8'($urandom);
      case ($urandom % 10)
        0: f_rstdaa();
        1: f_bc_rstact(8'($urandom_range(0, 3)));
        2: f_ignored(1'b1, 8'h8F, 8'($urandom));
        3: f_ignored(1'b0, {raddr(), 1'b0}, 8'h87);
        default: begin
          code = codes[$urandom % 3];
          f_direct(code, 8'($urandom_range(0, 3)), tgt,
                   (code == 8'h9A) ? bit'($urandom % 2) : ($urandom % 10 == 0),
                   data, ($urandom % 8) == 0, 1'b1);
        end
      endcase
    end

    cyc(10);
    check("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
